// File: rtl/konami_acceptor.sv
// ============================================================================
// konami_acceptor : button synchroniser/edge detector and Konami-code tracker
// Revision 1.0    : initial release
// ============================================================================
`default_nettype none

module konami_acceptor #(
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int HOLD_CYCLES    = 100000000,
    parameter int CNT_W          = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_b,
    input  logic       btn_a,
    output logic [3:0] state,
    output logic       unlocked,
    output logic       unlock_pulse
);

    localparam logic [3:0] c_ST_IDLE     = 4'd0;
    localparam logic [3:0] c_ST_UU       = 4'd2;
    localparam logic [3:0] c_ST_LAST     = 4'd9;
    localparam logic [3:0] c_ST_UNLOCKED = 4'd10;

    localparam logic [5:0] c_BTN_U = 6'b000001;
    localparam logic [5:0] c_BTN_D = 6'b000010;
    localparam logic [5:0] c_BTN_L = 6'b000100;
    localparam logic [5:0] c_BTN_R = 6'b001000;
    localparam logic [5:0] c_BTN_B = 6'b010000;
    localparam logic [5:0] c_BTN_A = 6'b100000;

    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

    logic [5:0]       w_raw;
    logic [5:0]       r_sync1, r_sync2, r_sync3;
    logic [5:0]       w_press;
    logic             w_any_event;
    logic             w_valid_event;
    logic [5:0]       w_expected;
    logic [3:0]       r_state, w_next_state;
    logic [CNT_W-1:0] r_timer, w_next_timer;
    logic             r_unlocked, w_next_unlocked;
    logic             r_pulse, w_next_pulse;

    assign w_raw = {btn_a, btn_b, btn_right, btn_left, btn_down, btn_up};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_press       = r_sync2 & ~r_sync3;
    assign w_any_event   = |w_press;
    // one-hot test: clearing the lowest set bit leaves nothing
    assign w_valid_event = w_any_event && ((w_press & (w_press - 6'd1)) == 6'd0);

    always_comb begin
        w_expected = 6'b000000;
        case (r_state)
            4'd0, 4'd1: w_expected = c_BTN_U;
            4'd2, 4'd3: w_expected = c_BTN_D;
            4'd4, 4'd6: w_expected = c_BTN_L;
            4'd5, 4'd7: w_expected = c_BTN_R;
            4'd8:       w_expected = c_BTN_B;
            4'd9:       w_expected = c_BTN_A;
            default:    w_expected = 6'b000000;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_timer    <= '0;
            r_unlocked <= 1'b0;
            r_pulse    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_timer    <= w_next_timer;
            r_unlocked <= w_next_unlocked;
            r_pulse    <= w_next_pulse;
        end
    end

    // Next-state logic; an event always wins over a coincident timeout
    always_comb begin
        w_next_state = r_state;
        if (r_state > c_ST_UNLOCKED) begin
            w_next_state = c_ST_IDLE;
        end else if (r_state == c_ST_UNLOCKED) begin
            if (r_timer == c_HOLD_LAST) begin
                w_next_state = c_ST_IDLE;
            end
        end else if (w_any_event) begin
            if (w_valid_event && (w_press == w_expected)) begin
                w_next_state = r_state + 4'd1;
            end else if (w_valid_event && (w_press == c_BTN_U)) begin
                w_next_state = (r_state == c_ST_UU) ? c_ST_UU : 4'd1;
            end else begin
                w_next_state = c_ST_IDLE;
            end
        end else if ((r_state != c_ST_IDLE) && (r_timer == c_TIMEOUT_LAST)) begin
            w_next_state = c_ST_IDLE;
        end

        // any press restarts the idle/hold window, even while unlocked
        w_next_timer = '0;
        if ((w_next_state == r_state) && !w_any_event && (r_state != c_ST_IDLE)) begin
            w_next_timer = r_timer + 1'b1;
        end
    end

    // Output logic (registered one cycle later with the state)
    always_comb begin
        w_next_unlocked = (w_next_state == c_ST_UNLOCKED);
        w_next_pulse    = (w_next_state == c_ST_UNLOCKED) && (r_state == c_ST_LAST);
    end

    assign state        = r_state;
    assign unlocked     = r_unlocked;
    assign unlock_pulse = r_pulse;

endmodule

`default_nettype wire

// File: doc/konami_acceptor.md
Name: konami_acceptor

Overview:
- Sequential front end of the Konami-code display path.
- Synchronises six raw push-button inputs and detects their rising edges.
- Tracks progress through the sequence Up Up Down Down Left Right Left Right B A.
- Drives the 4-bit state code consumed by the downstream seven-segment character decoder, plus unlock indications for the rest of the design.

Parameters:
- TIMEOUT_CYCLES, 50000000, idle cycles allowed between presses while in states 1..9 before falling back to 0.
- HOLD_CYCLES, 100000000, cycles that state 10 (unlocked) is held before returning to 0.
- CNT_W, 27, timer width; must satisfy 2^CNT_W > max(TIMEOUT_CYCLES, HOLD_CYCLES).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_up  input  1  raw Up button, active-high, asynchronous to clk.
- btn_down  input  1  raw Down button.
- btn_left  input  1  raw Left button.
- btn_right  input  1  raw Right button.
- btn_b  input  1  raw B button.
- btn_a  input  1  raw A button.
- state  output  4  progress code, 0..10; registered.
- unlocked  output  1  high while state == 10; registered.
- unlock_pulse  output  1  one-cycle pulse on entry to state 10.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). All outputs, synchroniser flops, edge flops and the timer clear to 0 on assertion. Release is synchronous to clk.
- Input path, per button: 2-flop synchroniser s1→s2, then delay flop s3. Press event is s2 & ~s3. Holding a button produces exactly one event.
- Latency: a button rising before clk edge N is reflected in state after edge N+2, i.e. a 3-cycle latency.
- Valid event: exactly one of the six press events is high in a cycle.
- Invalid event: two or more press events in the same cycle. This is treated as a wrong press.
- State codes:
  - 0 idle
  - 1 U
  - 2 UU
  - 3 UUD
  - 4 UUDD
  - 5 +L
  - 6 +R
  - 7 +L
  - 8 +R
  - 9 +B
  - 10 unlocked
  - Codes 11..15 are unreachable; if entered, the next cycle goes to 0.
- Expected button per state: 0:U, 1:U, 2:D, 3:D, 4:L, 5:R, 6:L, 7:R, 8:B, 9:A.
- Transitions for states 0..9:
  - Expected valid event: advance to state+1.
  - Wrong valid Up event: go to 1. Exception: Up in state 2 stays at 2 (UUU still ends in UU).
  - Any other wrong event, including invalid multi-press: go to 0.
- State 10: all press events are ignored. When the timer reaches HOLD_CYCLES-1, go to 0.
- Timer:
  - Clears to 0 on every state change and on every valid or invalid event.
  - Otherwise increments while state is 1..10; held at 0 in state 0.
  - In states 1..9, timer == TIMEOUT_CYCLES-1 with no event that cycle causes state to go to 0.
  - An event in the same cycle as the timeout takes priority: the transition is as for the event.
  - The timer never wraps: timeout and hold fire before overflow.
- Outputs:
  - unlocked is registered, high exactly while state == 10.
  - unlock_pulse is high for the single cycle after the 9→10 transition, aligned with the first cycle state reads 10.
- Reset mid-sequence: state returns to 0 immediately. A button held through reset release produces an event only if s3 sees a 0→1 transition after release; s3 resets to 0, so a held button produces one event after release.

Test Plan (TIMEOUT_CYCLES=16, HOLD_CYCLES=8):
1. Full sequence U,U,D,D,L,R,L,R,B,A, each a 4-cycle press with 4-cycle gaps → state steps 1..10; unlock_pulse high exactly 1 cycle; unlocked high for 8 cycles; state then returns to 0.
2. U,U,U,D → state 1,2,2,3. Then U,U,L → 1,2,0.
3. U then no press for 16 cycles → state 1 for 16 cycles, then 0. Repeat with a D press landing exactly on the timeout cycle, after U,U → state becomes 3, not 0.
4. Reach state 4, then press L and R in the same cycle → state 0, unlocked stays 0.
5. Hold btn_up high for 40 cycles → exactly one event; state 1, returning to 0 via timeout. Verify state changes 3 cycles after the rising input.
6. Assert rst_n low asynchronously mid-clock while in state 7 → state=0, unlocked=0 and unlock_pulse=0 immediately, before the next clk edge. Also, in state 10, pressing U,U leaves state at 10 until hold expires.
